// File: rtl/msx_audio_mixer_pkg.sv
// Shared types and helpers for the time-multiplexed audio mixer.
package msx_mix_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} mix_state_t;

  // Accumulator wide enough that a full sweep of worst-case products cannot wrap.
  function automatic int unsigned acc_width(input int unsigned channels,
                                            input int unsigned in_w,
                                            input int unsigned gain_w);
    return in_w + gain_w + 1 + $clog2(channels);
  endfunction

  // Clamp to the signed out_w range; clip reports whether clamping happened.
  function automatic logic signed [63:0] sat_clamp(input  logic signed [63:0] s,
                                                   input  int unsigned        out_w,
                                                   output logic               clip);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (out_w - 1));
    clip = 1'b1;
    if (s > hi) begin
      res = hi;
    end else if (s < lo) begin
      res = lo;
    end else begin
      res  = s;
      clip = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/msx_audio_mixer_if.sv
// Sample/control bundle between the audio sources and the mixer.
interface msx_audio_mixer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned GAIN_W   = 4,
  parameter int unsigned OUT_W    = 16
);
  logic                       sample_stb;
  logic [CHANNELS*IN_W-1:0]   ch_data;
  logic [CHANNELS-1:0]        ch_signed;
  logic [CHANNELS*GAIN_W-1:0] ch_gain;
  logic signed [OUT_W-1:0]    audio_out;
  logic                       audio_vld;
  logic                       busy;
  logic                       overrun;
  logic                       clip;
  logic                       clip_led;

  modport master (
    output sample_stb, ch_data, ch_signed, ch_gain,
    input  audio_out, audio_vld, busy, overrun, clip, clip_led
  );

  modport slave (
    input  sample_stb, ch_data, ch_signed, ch_gain,
    output audio_out, audio_vld, busy, overrun, clip, clip_led
  );
endinterface

// File: rtl/msx_audio_mixer_sat.sv
// Arithmetic shift by the gain fraction and clamp of the accumulator to the output width.
module msx_mix_sat
  import msx_mix_pkg::*;
#(
  parameter int unsigned ACC_W     = 23,
  parameter int unsigned GAIN_FRAC = 2,
  parameter int unsigned OUT_W     = 16
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_clip
);

  logic signed [63:0] w_shift;
  logic signed [63:0] w_clamped;
  logic               w_clip;
  logic               w_unused_hi;

  assign w_shift = 64'(i_acc) >>> GAIN_FRAC;

  always_comb begin
    w_clip    = 1'b0;
    w_clamped = sat_clamp(w_shift, OUT_W, w_clip);
  end

  assign o_sample    = w_clamped[OUT_W-1:0];
  assign o_clip      = w_clip;
  // Upper bits are pure sign extension once clamped.
  assign w_unused_hi = ^w_clamped[63:OUT_W];

endmodule

// File: rtl/msx_audio_mixer.sv
// N-channel mixer: one channel per clock through a shared MAC, then shift/clamp.
// Optional clip LED stretch enabled by defining MSX_MIX_CLIP_HOLD_EN.
module msx_audio_mixer
  import msx_mix_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned IN_W      = 16,
  parameter int unsigned GAIN_W    = 4,
  parameter int unsigned GAIN_FRAC = 2,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned CLIP_HOLD = 1000000
) (
  input logic              clk_sys,
  input logic              reset,
  msx_audio_mixer_if.slave io_bus
);

  localparam int unsigned ACC_W  = acc_width(CHANNELS, IN_W, GAIN_W);
  localparam int unsigned PROD_W = IN_W + GAIN_W + 1;
  localparam int unsigned IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  mix_state_t r_state;
  mix_state_t w_state_next;

  logic [CHANNELS*IN_W-1:0]   r_data;
  logic [CHANNELS-1:0]        r_signed;
  logic [CHANNELS*GAIN_W-1:0] r_gain;
  logic signed [ACC_W-1:0]    r_acc;
  logic [IDX_W-1:0]           r_idx;
  logic signed [OUT_W-1:0]    r_audio_out;
  logic                       r_vld;
  logic                       r_clip;
  logic                       r_overrun;

  logic                       w_busy;
  logic                       w_start;
  logic                       w_acc_en;
  logic                       w_sat_en;
  logic                       w_last;
  logic [IN_W-1:0]            w_raw;
  logic [IN_W-1:0]            w_samp;
  logic [GAIN_W-1:0]          w_gain;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_term;
  logic signed [OUT_W-1:0]    w_sat_sample;
  logic                       w_sat_clip;

  assign w_last = (r_idx == IDX_W'(CHANNELS - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (io_bus.sample_stb) w_state_next = ACCUM;
      ACCUM:   if (w_last) w_state_next = SAT;
      SAT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_start  = 1'b0;
    w_acc_en = 1'b0;
    w_sat_en = 1'b0;
    unique case (r_state)
      IDLE:  w_start = io_bus.sample_stb;
      ACCUM: begin
        w_busy   = 1'b1;
        w_acc_en = 1'b1;
      end
      SAT: begin
        w_busy   = 1'b1;
        w_sat_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared multiplier: offset-binary samples get their MSB flipped into two's complement.
  assign w_raw  = r_data[r_idx*IN_W +: IN_W];
  assign w_samp = r_signed[r_idx] ? w_raw : {~w_raw[IN_W-1], w_raw[IN_W-2:0]};
  assign w_gain = r_gain[r_idx*GAIN_W +: GAIN_W];
  assign w_prod = $signed({{(GAIN_W + 1){w_samp[IN_W-1]}}, w_samp}) *
                  $signed({{(IN_W + 1){1'b0}}, w_gain});
  assign w_term = ACC_W'(w_prod);

  msx_mix_sat #(
    .ACC_W     (ACC_W),
    .GAIN_FRAC (GAIN_FRAC),
    .OUT_W     (OUT_W)
  ) u_sat (
    .i_acc    (r_acc),
    .o_sample (w_sat_sample),
    .o_clip   (w_sat_clip)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_data      <= '0;
      r_signed    <= '0;
      r_gain      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_audio_out <= '0;
      r_vld       <= 1'b0;
      r_clip      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vld <= w_sat_en;
      if (w_start) begin
        r_data   <= io_bus.ch_data;
        r_signed <= io_bus.ch_signed;
        r_gain   <= io_bus.ch_gain;
        r_acc    <= '0;
        r_idx    <= '0;
      end
      if (w_acc_en) begin
        r_acc <= r_acc + w_term;
        r_idx <= r_idx + 1'b1;
      end
      if (w_sat_en) begin
        r_audio_out <= w_sat_sample;
        r_clip      <= w_sat_clip;
      end
      if (io_bus.sample_stb && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef MSX_MIX_CLIP_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(CLIP_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_clip_led;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hold     <= '0;
      r_clip_led <= 1'b0;
    end else if (w_sat_en && w_sat_clip) begin
      r_hold     <= HOLD_W'(CLIP_HOLD - 1);
      r_clip_led <= 1'b1;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end else begin
      r_clip_led <= 1'b0;
    end
  end

  assign io_bus.clip_led = r_clip_led;
`else
  logic w_unused_hold;

  assign w_unused_hold   = ^CLIP_HOLD;
  assign io_bus.clip_led = r_clip;
`endif

  assign io_bus.audio_out = r_audio_out;
  assign io_bus.audio_vld = r_vld;
  assign io_bus.busy      = w_busy;
  assign io_bus.overrun   = r_overrun;
  assign io_bus.clip      = r_clip;

endmodule
